// File: rtl/linalg_pkg.sv
// Shared definitions for the LinearAlgebraLayer blocks: FSM encodings, strobe
// bit positions and the width helper for difference lanes.
package linalg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_L0   = 2'd1;
    localparam logic [1:0] ST_L1   = 2'd2;
    localparam logic [1:0] ST_L2   = 2'd3;

    // Bit positions inside the registered strobe vector.
    localparam int STB_OUT_READY  = 0;
    localparam int STB_IN_DROPPED = 1;
    localparam int NUM_STROBES    = 2;

    localparam int SERIAL_LATENCY = 3;

    function automatic int sub_width(input int in_width);
        return in_width + 2;
    endfunction

endpackage

// File: rtl/serial_sub_datapath.sv
// Lane-select mux, sign extension and the single subtractor shared by all
// three lanes. Purely combinational; the owning FSM supplies the lane select.
module serial_sub_datapath
    import linalg_pkg::*;
#(
    parameter int IN_WIDTH = 10
) (
    input  logic [1:0]                            sel,
    input  logic signed [IN_WIDTH:0]              s0,
    input  logic signed [IN_WIDTH:0]              s1,
    input  logic signed [IN_WIDTH:0]              s2,
    input  logic signed [IN_WIDTH-1:0]            b0,
    input  logic signed [IN_WIDTH-1:0]            b1,
    input  logic signed [IN_WIDTH-1:0]            b2,
    output logic signed [sub_width(IN_WIDTH)-1:0] diff
);

    localparam int DW = sub_width(IN_WIDTH);

    logic signed [IN_WIDTH:0]   s_mux;
    logic signed [IN_WIDTH-1:0] b_mux;
    logic signed [DW-1:0]       s_ext;
    logic signed [DW-1:0]       b_ext;

    always_comb begin
        s_mux = s0;
        b_mux = b0;
        case (sel)
            ST_L1:   begin s_mux = s1; b_mux = b1; end
            ST_L2:   begin s_mux = s2; b_mux = b2; end
            default: begin s_mux = s0; b_mux = b0; end
        endcase
    end

    // Two guard bits make the difference exact for every operand pair.
    always_comb begin
        s_ext = {{(DW-IN_WIDTH-1){s_mux[IN_WIDTH]}}, s_mux};
        b_ext = {{(DW-IN_WIDTH){b_mux[IN_WIDTH-1]}}, b_mux};
        diff  = s_ext - b_ext;
    end

endmodule

// File: rtl/vector_sub_3_serial.sv
// Three-lane vector subtractor D = S - B using one time-shared subtractor.
// Handshake: inReady is a one-cycle strobe, accepted in IDLE or L2; outReady is a one-cycle strobe when D0..D2 update.
module vector_sub_3_serial
    import linalg_pkg::*;
#(
    parameter int IN_WIDTH = 10
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  inReady,
    input  logic signed [IN_WIDTH:0]              S0,
    input  logic signed [IN_WIDTH:0]              S1,
    input  logic signed [IN_WIDTH:0]              S2,
    input  logic signed [IN_WIDTH-1:0]            B0,
    input  logic signed [IN_WIDTH-1:0]            B1,
    input  logic signed [IN_WIDTH-1:0]            B2,
    output logic                                  busy,
    output logic                                  outReady,
    output logic                                  earlyOutReady,
    output logic                                  inDropped,
    output logic signed [sub_width(IN_WIDTH)-1:0] D0,
    output logic signed [sub_width(IN_WIDTH)-1:0] D1,
    output logic signed [sub_width(IN_WIDTH)-1:0] D2
);

    localparam int DW = sub_width(IN_WIDTH);

    logic [1:0]                 state_q, state_d;
    logic signed [IN_WIDTH:0]   s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
    logic signed [IN_WIDTH-1:0] b0_q, b1_q, b2_q, b0_d, b1_d, b2_d;
    logic signed [DW-1:0]       d0_stage_q, d1_stage_q, d0_stage_d, d1_stage_d;
    logic signed [DW-1:0]       d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
    logic [NUM_STROBES-1:0]     strobe_q, strobe_d;
    logic signed [DW-1:0]       diff;
    logic                       can_accept;
    logic                       accept;

    serial_sub_datapath #(.IN_WIDTH(IN_WIDTH)) u_datapath (
        .sel  (state_q),
        .s0   (s0_q),
        .s1   (s1_q),
        .s2   (s2_q),
        .b0   (b0_q),
        .b1   (b1_q),
        .b2   (b2_q),
        .diff (diff)
    );

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_L2);
    assign accept     = enable && inReady && can_accept;

    always_comb begin
        state_d    = state_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        d0_stage_d = d0_stage_q;
        d1_stage_d = d1_stage_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        strobe_d   = '0;

        if (enable) begin
            strobe_d[STB_IN_DROPPED] = inReady && !can_accept;
            case (state_q)
                ST_IDLE: state_d = accept ? ST_L0 : ST_IDLE;
                ST_L0: begin
                    d0_stage_d = diff;
                    state_d    = ST_L1;
                end
                ST_L1: begin
                    d1_stage_d = diff;
                    state_d    = ST_L2;
                end
                default: begin
                    // D2 comes from the old capture registers on the same edge a new vector may load.
                    d0_d                    = d0_stage_q;
                    d1_d                    = d1_stage_q;
                    d2_d                    = diff;
                    strobe_d[STB_OUT_READY] = 1'b1;
                    state_d                 = accept ? ST_L0 : ST_IDLE;
                end
            endcase
            if (accept) begin
                s0_d = S0;
                s1_d = S1;
                s2_d = S2;
                b0_d = B0;
                b1_d = B1;
                b2_d = B2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            d0_stage_q <= '0;
            d1_stage_q <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            strobe_q   <= '0;
        end else begin
            state_q    <= state_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            d0_stage_q <= d0_stage_d;
            d1_stage_q <= d1_stage_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            strobe_q   <= strobe_d;
        end
    end

    assign busy          = (state_q == ST_L0) || (state_q == ST_L1);
    assign earlyOutReady = (state_q == ST_L2) && enable;
    assign outReady      = strobe_q[STB_OUT_READY];
    assign inDropped     = strobe_q[STB_IN_DROPPED];
    assign D0            = d0_q;
    assign D1            = d1_q;
    assign D2            = d2_q;

endmodule

// File: tb/tb_vector_sub_3_serial.sv
// Bench for vector_sub_3_serial: table vectors, random back-to-back traffic and
// hand sequences for overrun, enable stall and mid-operation reset.
module tb_vector_sub_3_serial;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               inReady;
  logic signed [10:0] S0, S1, S2;
  logic signed [9:0]  B0, B1, B2;
  logic               busy, outReady, earlyOutReady, inDropped;
  logic signed [11:0] D0, D1, D2;

  vector_sub_3_serial #(.IN_WIDTH(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .inReady       (inReady),
    .S0            (S0),
    .S1            (S1),
    .S2            (S2),
    .B0            (B0),
    .B1            (B1),
    .B2            (B2),
    .busy          (busy),
    .outReady      (outReady),
    .earlyOutReady (earlyOutReady),
    .inDropped     (inDropped),
    .D0            (D0),
    .D1            (D1),
    .D2            (D2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int s0, s1, s2;
    int b0, b1, b2;
    int d0, d1, d2;
  } vec_t;

  logic [35:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          drop_cnt = 0;
  int          last_out = -1;
  bit          gap_mode = 1'b0;
  vec_t        vecs[6];

  function automatic vec_t mk(int s0, int s1, int s2, int b0, int b1, int b2,
                              int d0, int d1, int d2);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    return v;
  endfunction

  function automatic logic [35:0] pack_exp(vec_t v);
    return {12'(v.d0), 12'(v.d1), 12'(v.d2)};
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock; observe outputs 1 time unit after the edge and score any result.
  task automatic tick();
    logic [35:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (inDropped) drop_cnt++;
    if (outReady) begin
      out_cnt++;
      if (gap_mode && last_out >= 0) check("out_gap", 36'(cyc - last_out), 36'd3);
      last_out = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got outReady with D=%0h, expected no result (cycle %0d)",
                 {D0, D1, D2}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("d_vec", {D0, D1, D2}, e);
      end
    end
  endtask

  // driver tasks
  task automatic set_inputs(input vec_t v);
    S0 = 11'(v.s0); S1 = 11'(v.s1); S2 = 11'(v.s2);
    B0 = 10'(v.b0); B1 = 10'(v.b1); B2 = 10'(v.b2);
  endtask

  task automatic drive(input vec_t v);
    set_inputs(v);
    inReady = 1'b1;
    exp_q.push_back(pack_exp(v));
  endtask

  // Apply one vector and spend exactly three cycles, so the next call lands in L2.
  task automatic apply_vec(input vec_t v);
    drive(v);
    tick();
    inReady = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain_outstanding", 36'(exp_q.size()), 36'd0);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.s0 = int'($urandom_range(0, 2047)) - 1024;
    v.s1 = int'($urandom_range(0, 2047)) - 1024;
    v.s2 = int'($urandom_range(0, 2047)) - 1024;
    v.b0 = int'($urandom_range(0, 1023)) - 512;
    v.b1 = int'($urandom_range(0, 1023)) - 512;
    v.b2 = int'($urandom_range(0, 1023)) - 512;
    v.d0 = v.s0 - v.b0;
    v.d1 = v.s1 - v.b1;
    v.d2 = v.s2 - v.b2;
    return v;
  endfunction

  initial begin
    vec_t v, v2;
    int   d_before, o_before;

    vecs[0] = mk(100, -5, 0, 30, -7, 511, 70, 2, -511);
    vecs[1] = mk(-1024, 1023, -1024, 511, -512, -512, -1535, 1535, -512);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(1023, -1024, 1, -512, 511, -1, 1535, -1535, 2);
    vecs[4] = mk(-1, 300, -700, -1, -300, 200, 0, 600, -900);
    vecs[5] = mk(512, -512, 7, 511, -511, 8, 1, -1, -1);

    reset = 1'b0; enable = 1'b1; inReady = 1'b0;
    S0 = '0; S1 = '0; S2 = '0; B0 = '0; B1 = '0; B2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_out_ready", outReady, 1'b0);
    check("rst_early", earlyOutReady, 1'b0);
    check("rst_dropped", inDropped, 1'b0);
    check("rst_d", {D0, D1, D2}, 36'd0);
    reset = 1'b1;
    tick();

    // Single vector with cycle-exact handshake timing.
    drive(vecs[0]);
    tick();
    inReady = 1'b0;
    check("t1_busy_l0", busy, 1'b1);
    check("t1_early_l0", earlyOutReady, 1'b0);
    tick();
    check("t1_busy_l1", busy, 1'b1);
    check("t1_early_l1", earlyOutReady, 1'b0);
    tick();
    check("t1_early_l2", earlyOutReady, 1'b1);
    check("t1_busy_l2", busy, 1'b0);
    check("t1_out_l2", outReady, 1'b0);
    tick();
    check("t1_out_e3", outReady, 1'b1);
    check("t1_early_after", earlyOutReady, 1'b0);
    tick();
    check("t1_out_pulse", outReady, 1'b0);
    check("t1_hold", {D0, D1, D2}, 36'h046002e01);
    tick();

    // Table vectors back-to-back, then random ones, one accept every 3 cycles.
    gap_mode = 1'b1;
    last_out = -1;
    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);
    for (int i = 0; i < 6; i++) apply_vec(rand_vec());
    drain();
    gap_mode = 1'b0;
    check("b2b_out_count", 36'(out_cnt), 36'd13);
    check("b2b_no_drop", 36'(drop_cnt), 36'd0);
    tick();

    // Overrun: second strobe one cycle after capture is rejected.
    d_before = drop_cnt;
    o_before = out_cnt;
    v  = mk(-300, 40, 5, 200, -60, -5, -500, 100, 10);
    v2 = mk(7, 7, 7, 1, 1, 1, 6, 6, 6);
    drive(v);
    tick();
    set_inputs(v2);
    inReady = 1'b1;
    check("ovr_busy_l0", busy, 1'b1);
    tick();
    inReady = 1'b0;
    check("ovr_dropped", inDropped, 1'b1);
    check("ovr_busy_l1", busy, 1'b1);
    tick();
    check("ovr_dropped_pulse", inDropped, 1'b0);
    drain();
    repeat (3) tick();
    check("ovr_drop_count", 36'(drop_cnt - d_before), 36'd1);
    check("ovr_out_count", 36'(out_cnt - o_before), 36'd1);

    // Enable stall in L1, strobes ignored while frozen.
    d_before = drop_cnt;
    o_before = out_cnt;
    v = mk(1000, -1000, 64, -500, 500, 64, 1500, -1500, 0);
    drive(v);
    tick();
    inReady = 1'b0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inReady = (i % 2 == 0);
      tick();
      check("stall_busy", busy, 1'b1);
      check("stall_pulses", {outReady, earlyOutReady, inDropped}, 3'b000);
    end
    inReady = 1'b0;
    enable = 1'b1;
    tick();
    check("stall_early_l2", earlyOutReady, 1'b1);
    enable = 1'b0;
    tick();
    check("stall_l2_gated", {outReady, earlyOutReady}, 2'b00);
    enable = 1'b1;
    tick();
    check("stall_out", outReady, 1'b1);
    check("stall_out_count", 36'(out_cnt - o_before), 36'd1);
    check("stall_no_drop", 36'(drop_cnt - d_before), 36'd0);
    tick();

    // Reset in L1: everything clears at once and the vector never emerges.
    o_before = out_cnt;
    v = mk(5, 6, 7, 1, 2, 3, 4, 4, 4);
    drive(v);
    tick();
    inReady = 1'b0;
    tick();
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_d", {D0, D1, D2}, 36'd0);
    check("mid_rst_ctl", {busy, outReady, earlyOutReady, inDropped}, 4'b0000);
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("mid_rst_no_out", 36'(out_cnt - o_before), 36'd0);
    apply_vec(mk(-1024, -1024, 1023, -512, 511, 511, -512, -1535, 512));
    drain();

    check("final_queue_empty", 36'(exp_q.size()), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
